// File: rtl/btn_sw_conditioner_if.sv
// btn_sw_conditioner_if
//   Bundles the raw pin inputs and conditioned outputs of btn_sw_conditioner.
//   master : drives RAW_IN, observes the conditioned outputs (board logic / bench)
//   slave  : receives RAW_IN, drives the conditioned outputs (the conditioner)
//   Signals (all N_CH wide):
//     RAW_IN     asynchronous raw pin levels
//     DB_LEVEL   debounced level
//     DB_RISE    one-cycle pulse on a debounced 0->1 change
//     DB_FALL    one-cycle pulse on a debounced 1->0 change
//     DB_TOGGLE  flips on every debounced rise
`timescale 1ns / 1ps

interface btn_sw_conditioner_if #(
    parameter int unsigned N_CH = 8
);
    logic [N_CH-1:0] RAW_IN;
    logic [N_CH-1:0] DB_LEVEL;
    logic [N_CH-1:0] DB_RISE;
    logic [N_CH-1:0] DB_FALL;
    logic [N_CH-1:0] DB_TOGGLE;

    modport master (
        output RAW_IN,
        input  DB_LEVEL,
        input  DB_RISE,
        input  DB_FALL,
        input  DB_TOGGLE
    );

    modport slave (
        input  RAW_IN,
        output DB_LEVEL,
        output DB_RISE,
        output DB_FALL,
        output DB_TOGGLE
    );
endinterface

// File: rtl/btn_sw_conditioner.sv
// btn_sw_conditioner
//   Cleans up the board push-buttons and slide switches before the top-level logic
//   uses them. Each channel is synchronised through SYNC_STAGES flops and then
//   debounced: a new value is accepted only after it has been seen for
//   DEBOUNCE_CYCLES consecutive clocks. Every output is a flop.
//   Ports:
//     CLK    system clock, rising edge
//     RST_N  asynchronous active-low reset, clears every flop
//     bus    btn_sw_conditioner_if slave: RAW_IN in, DB_LEVEL/DB_RISE/DB_FALL/DB_TOGGLE out
//   Parameters:
//     N_CH             number of channels
//     SYNC_STAGES      synchroniser depth, 2..4
//     DEBOUNCE_CYCLES  stability requirement in clocks, >= 1
`timescale 1ns / 1ps

module btn_sw_conditioner #(
    parameter int unsigned N_CH            = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input logic                 CLK,
    input logic                 RST_N,
    btn_sw_conditioner_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // Terminal count: reaching it while still mismatched accepts the new level.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.RAW_IN;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel debounce counters and output flops
    // ------------------------------------------------------------------
    logic [CntW-1:0] cnt_q [N_CH];
    logic [CntW-1:0] cnt_d [N_CH];
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] tog_q, tog_d;

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] == level_q[i]) begin
                // Any agreement breaks the mismatch run.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
        // Pulses are registered alongside the level so they coincide with it.
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        tog_d  = tog_q ^ rise_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            tog_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tog_q   <= tog_d;
        end
    end

    assign bus.DB_LEVEL  = level_q;
    assign bus.DB_RISE   = rise_q;
    assign bus.DB_FALL   = fall_q;
    assign bus.DB_TOGGLE = tog_q;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// tb_btn_sw_conditioner
//   Directed stimulus for btn_sw_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
//   A window-based model (a value is accepted once the synchronised input has
//   disagreed with the level for the last DEBOUNCE_CYCLES edges) is compared with
//   the DUT every cycle; hand-computed literal checks pin the model.
`timescale 1ns / 1ps

module tb_btn_sw_conditioner;

    localparam int unsigned NCh  = 8;
    localparam int unsigned Sync = 2;
    localparam int unsigned Db   = 4;

    logic CLK;
    logic RST_N;

    btn_sw_conditioner_if #(.N_CH(NCh)) bus ();

    btn_sw_conditioner #(
        .N_CH           (NCh),
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(Db)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Model: history of raw samples taken at each active edge
    // ------------------------------------------------------------------
    logic [NCh-1:0] rhist [$];
    logic [NCh-1:0] m_lvl, m_rise, m_fall, m_tog;

    int rise2_cnt = 0;
    int ev3 [$];

    task automatic model_clear();
        rhist.delete();
        // Synchroniser flops come out of reset at 0.
        for (int k = 0; k < Sync + Db; k++) rhist.push_back('0);
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_tog  = '0;
    endtask

    task automatic model_step(input logic [NCh-1:0] raw);
        int  last;
        bit  stable;
        rhist.push_back(raw);
        if (rhist.size() > 64) void'(rhist.pop_front());
        last   = rhist.size() - 1;
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < NCh; ch++) begin
            // Value seen by the debouncer at this edge was sampled Sync edges ago.
            stable = 1'b1;
            for (int k = 0; k < Db; k++) begin
                if (rhist[last - Sync - k][ch] == m_lvl[ch]) stable = 1'b0;
            end
            if (stable) begin
                m_lvl[ch] = ~m_lvl[ch];
                if (m_lvl[ch]) begin
                    m_rise[ch] = 1'b1;
                    m_tog[ch]  = ~m_tog[ch];
                end else begin
                    m_fall[ch] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_clear();
                #1;
            end else begin
                model_step(bus.RAW_IN);
                #1;
                if (bus.DB_RISE[2]) rise2_cnt++;
                if (bus.DB_RISE[3]) ev3.push_back(1);
                if (bus.DB_FALL[3]) ev3.push_back(2);
            end
            check("model level",  32'(bus.DB_LEVEL),  32'(m_lvl));
            check("model rise",   32'(bus.DB_RISE),   32'(m_rise));
            check("model fall",   32'(bus.DB_FALL),   32'(m_fall));
            check("model toggle", 32'(bus.DB_TOGGLE), 32'(m_tog));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    logic pat [5];
    int   code;

    initial begin
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        RST_N      = 1'b0;
        bus.RAW_IN = '0;
        repeat (3) @(negedge CLK);
        check("reset level",  32'(bus.DB_LEVEL),  32'h00);
        check("reset toggle", 32'(bus.DB_TOGGLE), 32'h00);
        RST_N = 1'b1;

        // Idle inputs stay quiet.
        repeat (20) @(posedge CLK);
        #1;
        check("idle level",  32'(bus.DB_LEVEL),  32'h00);
        check("idle rise",   32'(bus.DB_RISE),   32'h00);
        check("idle toggle", 32'(bus.DB_TOGGLE), 32'h00);

        // Channel 0 press: level appears after edge 6, never earlier.
        @(negedge CLK);
        bus.RAW_IN[0] = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("ch0 edge5 level", 32'(bus.DB_LEVEL), 32'h00);
        @(posedge CLK);
        #1;
        check("ch0 edge6 level",  32'(bus.DB_LEVEL),  32'h01);
        check("ch0 edge6 rise",   32'(bus.DB_RISE),   32'h01);
        check("ch0 edge6 toggle", 32'(bus.DB_TOGGLE), 32'h01);
        @(posedge CLK);
        #1;
        check("ch0 edge7 rise",  32'(bus.DB_RISE),  32'h00);
        check("ch0 edge7 level", 32'(bus.DB_LEVEL), 32'h01);

        // Channel 1 glitch of 3 cycles is rejected.
        @(negedge CLK);
        bus.RAW_IN[1] = 1'b1;
        repeat (3) @(negedge CLK);
        bus.RAW_IN[1] = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        check("ch1 glitch level", 32'(bus.DB_LEVEL), 32'h01);

        // Channel 2 bounce then stable 1.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.RAW_IN[2] = pat[i];
        end
        @(negedge CLK);
        bus.RAW_IN[2] = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("ch2 edge5 level", 32'(bus.DB_LEVEL), 32'h01);
        @(posedge CLK);
        #1;
        check("ch2 edge6 level",  32'(bus.DB_LEVEL),  32'h05);
        check("ch2 edge6 rise",   32'(bus.DB_RISE),   32'h04);
        check("ch2 edge6 toggle", 32'(bus.DB_TOGGLE), 32'h05);
        repeat (10) @(posedge CLK);
        #1;
        check("ch2 rise count", 32'(rise2_cnt), 32'd1);

        // Channel 3 press/release twice.
        for (int r = 0; r < 2; r++) begin
            @(negedge CLK);
            bus.RAW_IN[3] = 1'b1;
            repeat (10) @(negedge CLK);
            bus.RAW_IN[3] = 1'b0;
            repeat (9) @(negedge CLK);
        end
        repeat (2) @(posedge CLK);
        #1;
        code = 0;
        foreach (ev3[i]) code = code * 10 + ev3[i];
        check("ch3 event sequence", 32'(code), 32'd1212);
        check("ch3 toggle back",    32'(bus.DB_TOGGLE), 32'h05);
        check("ch3 level",          32'(bus.DB_LEVEL),  32'h05);

        // All channels high, reset pulsed mid-count.
        @(negedge CLK);
        bus.RAW_IN = 8'hFF;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #0.5;
        check("async clr level",  32'(bus.DB_LEVEL),  32'h00);
        check("async clr rise",   32'(bus.DB_RISE),   32'h00);
        check("async clr fall",   32'(bus.DB_FALL),   32'h00);
        check("async clr toggle", 32'(bus.DB_TOGGLE), 32'h00);
        #0.5;
        RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("all edge5 level", 32'(bus.DB_LEVEL), 32'h00);
        @(posedge CLK);
        #1;
        check("all edge6 level",  32'(bus.DB_LEVEL),  32'hFF);
        check("all edge6 rise",   32'(bus.DB_RISE),   32'hFF);
        check("all edge6 toggle", 32'(bus.DB_TOGGLE), 32'hFF);
        @(posedge CLK);
        #1;
        check("all edge7 rise", 32'(bus.DB_RISE), 32'h00);

        repeat (5) @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_sw_conditioner.md
Name: btn_sw_conditioner

Overview:
- Input-conditioning stage directly upstream of the board top-level logic. It feeds that logic clean versions of the Arty S7 push-buttons and slide switches.
- Each raw asynchronous pin is synchronised, then debounced with a per-channel stability counter.
- Outputs per channel: a clean level, single-cycle rise/fall pulses, and a toggle bit.
- The top-level LED/RGB logic consumes these outputs instead of raw BTN/SW.

Parameters:
- N_CH, 8, number of channels; bits [3:0] = BTN[3:0], bits [7:4] = SW[3:0] at instantiation.
- SYNC_STAGES, 2, flip-flops in the synchroniser chain (legal range 2..4).
- DEBOUNCE_CYCLES, 120000, consecutive clock cycles a new value must persist before acceptance (10 ms at 12 MHz; legal range >=1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- RAW_IN  input  N_CH  asynchronous raw pin levels.
- DB_LEVEL  output  N_CH  debounced level.
- DB_RISE  output  N_CH  one-cycle pulse when DB_LEVEL goes 0->1.
- DB_FALL  output  N_CH  one-cycle pulse when DB_LEVEL goes 1->0.
- DB_TOGGLE  output  N_CH  flips on every DB_RISE of that channel.

Behaviour:
- Reset is asynchronous and active-low: RST_N low immediately clears all synchroniser flops, counters, DB_LEVEL, DB_RISE, DB_FALL and DB_TOGGLE to 0, regardless of CLK.
- On reset release, no pulse is generated even if RAW_IN is 1. A channel held at 1 rises normally after the full latency.
- Channels are fully independent. There is no cross-channel interaction.
- Synchroniser: RAW_IN[i] passes through SYNC_STAGES flops. The last stage is called s[i].
- Counter:
  - Width is clog2(DEBOUNCE_CYCLES+1).
  - Each edge, if s[i] == DB_LEVEL[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: DB_LEVEL[i] <= s[i] and counter <= 0.
  - Else: counter <= counter+1.
- Latency: a RAW_IN change that is stable before edge 1 appears on DB_LEVEL after edge SYNC_STAGES+DEBOUNCE_CYCLES. It never appears earlier.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES cycles resets the counter. DB_LEVEL and the pulse outputs do not change.
- Pulses:
  - DB_RISE[i] / DB_FALL[i] are registered and high for exactly the one cycle in which the new DB_LEVEL first appears.
  - Otherwise they are 0.
  - DB_RISE and DB_FALL are never high together on one channel.
- Toggle: DB_TOGGLE[i] inverts on the same edge that raises DB_RISE[i]. Falls do not affect it.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- DEBOUNCE_CYCLES=1: the level updates on the first cycle s differs. Latency = SYNC_STAGES+1.
- Simultaneous changes on several channels produce pulses in the same cycle when their timing is identical.
- Reset asserted mid-count: the count is abandoned. After release, the full latency restarts from zero.
- Outputs are purely registered, with no combinational path from RAW_IN to any output.

Test Plan (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, N_CH=8):
- Reset, then RAW_IN=8'h00 for 20 cycles -> all outputs 0, no pulses.
- RAW_IN[0] 0->1 before edge 1, held -> DB_LEVEL[0]=1 after edge 6. DB_RISE[0]=1 for exactly that cycle. DB_TOGGLE[0]=1. Other bits unchanged.
- Glitch: RAW_IN[1]=1 for 3 cycles then 0 -> DB_LEVEL[1], DB_RISE[1] and DB_FALL[1] stay 0 throughout.
- Bounce: RAW_IN[2] pattern 1,0,1,1,0,1,1,1,1,1... -> one DB_RISE[2] pulse only, 6 edges after the start of the final stable run.
- Press/release twice on RAW_IN[3], each phase 10 cycles -> sequence DB_RISE, DB_FALL, DB_RISE, DB_FALL, each 1 cycle wide. DB_TOGGLE[3] goes 0->1->0.
- RAW_IN=8'hFF held, RST_N pulsed low for 1 ns mid-count (cycle 3) -> outputs clear immediately. After release, all 8 DB_RISE bits pulse together 6 edges later.
